// File: rtl/unadd_seq_if.sv
// Valid/ready operand and result bundle for unadd_seq.
// The slave modport is the block's view; the master modport is the view of the logic around it.
interface unadd_seq_if #(
  parameter int IN_W  = 6,
  parameter int SUM_W = IN_W + 2
);
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] sum;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic [IN_W-1:0]  c;
  logic             out_valid;
  logic             out_ready;
  logic [IN_W-1:0]  d;
  logic             err;

  modport slave (
    input  in_valid, sum, a, b, c, out_ready,
    output in_ready, out_valid, d, err
  );

  modport master (
    output in_valid, sum, a, b, c, out_ready,
    input  in_ready, out_valid, d, err
  );
endinterface

// File: rtl/unadd_seq.sv
// Recovers d = sum - a - b - c with one shared subtractor over three cycles.
// Optional macro UNADD_SAT_EN: clamp d to 0..2^IN_W-1 instead of wrapping.
module unadd_seq #(
  parameter int IN_W  = 6,
  parameter int SUM_W = IN_W + 2,
  parameter int ACC_W = SUM_W + 2
) (
  input logic        clk,
  input logic        resetn,
  unadd_seq_if.slave io
);
  typedef enum logic [2:0] {IDLE, SUB1, SUB2, SUB3, DONE} state_t;

  localparam logic [ACC_W-1:0] D_MAX = ACC_W'((1 << IN_W) - 1);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, sub_op, diff;
  logic [IN_W-1:0]  a_r, b_r, c_r, d_r, d_nx;
  logic             err_r, err_nx, out_valid_r, fin_neg, fin_big;

  always_comb begin
    state_nx = state;
    sub_op   = '0;
    unique case (state)
      IDLE:    if (io.in_valid) state_nx = SUB1;
      SUB1:    begin sub_op = ACC_W'(a_r); state_nx = SUB2; end
      SUB2:    begin sub_op = ACC_W'(b_r); state_nx = SUB3; end
      SUB3:    begin sub_op = ACC_W'(c_r); state_nx = DONE; end
      DONE:    if (out_valid_r && io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Single subtractor; in SUB3 its output is the final signed result.
  assign diff    = acc - sub_op;
  assign fin_neg = diff[ACC_W-1];
  assign fin_big = !fin_neg && (diff > D_MAX);
  assign err_nx  = fin_neg || fin_big;

`ifdef UNADD_SAT_EN
  assign d_nx = fin_neg ? '0 : (fin_big ? D_MAX[IN_W-1:0] : diff[IN_W-1:0]);
`else
  assign d_nx = diff[IN_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      acc         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      d_r         <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (io.in_valid) begin
          acc <= ACC_W'(io.sum);
          a_r <= io.a;
          b_r <= io.b;
          c_r <= io.c;
        end
        SUB1, SUB2: acc <= diff;
        SUB3: begin
          acc         <= diff;
          d_r         <= d_nx;
          err_r       <= err_nx;
          out_valid_r <= 1'b1;
        end
        DONE: if (io.out_ready) out_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid_r;
  assign io.d         = d_r;
  assign io.err       = err_r;
endmodule

// File: tb/tb_unadd_seq.sv
// Directed vector table plus hand-written backpressure and mid-op reset sequences for unadd_seq.
module tb_unadd_seq;
  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  unadd_seq_if #(.IN_W(6), .SUM_W(8)) io ();
  unadd_seq #(.IN_W(6)) dut (.clk(clk), .resetn(resetn), .io(io));

  typedef struct packed {
    logic [7:0] s;
    logic [5:0] a, b, c, d;
    logic       e;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accept one operand set, scramble inputs afterwards, check latency and result.
  task automatic run_op(input string nm, input vec_t v);
    int lat;
    @(negedge clk);
    io.in_valid = 1'b1; io.sum = v.s; io.a = v.a; io.b = v.b; io.c = v.c;
    chk({nm, "/in_ready"}, 32'(io.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.sum = 8'($urandom); io.a = 6'($urandom); io.b = 6'($urandom); io.c = 6'($urandom);
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "/latency"}, 32'(lat), 4);
    chk({nm, "/d"}, 32'(io.d), 32'(v.d));
    chk({nm, "/err"}, 32'(io.err), 32'(v.e));
    if (io.out_ready) begin
      @(negedge clk);
      chk({nm, "/out_valid_clr"}, 32'(io.out_valid), 0);
      chk({nm, "/in_ready_back"}, 32'(io.in_ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{s: 8'd100, a: 6'd10, b: 6'd20, c: 6'd30, d: 6'd40, e: 1'b0};
`ifdef UNADD_SAT_EN
    vt[1] = '{s: 8'd0,   a: 6'd1,  b: 6'd0,  c: 6'd0,  d: 6'd0,  e: 1'b1};
    vt[2] = '{s: 8'd252, a: 6'd0,  b: 6'd0,  c: 6'd0,  d: 6'd63, e: 1'b1};
    vt[6] = '{s: 8'd255, a: 6'd63, b: 6'd63, c: 6'd63, d: 6'd63, e: 1'b1};
    vt[7] = '{s: 8'd0,   a: 6'd63, b: 6'd63, c: 6'd63, d: 6'd0,  e: 1'b1};
`else
    vt[1] = '{s: 8'd0,   a: 6'd1,  b: 6'd0,  c: 6'd0,  d: 6'd63, e: 1'b1};
    vt[2] = '{s: 8'd252, a: 6'd0,  b: 6'd0,  c: 6'd0,  d: 6'd60, e: 1'b1};
    vt[6] = '{s: 8'd255, a: 6'd63, b: 6'd63, c: 6'd63, d: 6'd2,  e: 1'b1};
    vt[7] = '{s: 8'd0,   a: 6'd63, b: 6'd63, c: 6'd63, d: 6'd3,  e: 1'b1};
`endif
    vt[3] = '{s: 8'd252, a: 6'd63, b: 6'd63, c: 6'd63, d: 6'd63, e: 1'b0};
    vt[4] = '{s: 8'd0,   a: 6'd0,  b: 6'd0,  c: 6'd0,  d: 6'd0,  e: 1'b0};
    vt[5] = '{s: 8'd7,   a: 6'd1,  b: 6'd1,  c: 6'd1,  d: 6'd4,  e: 1'b0};

    resetn = 1'b0;
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    io.sum = '0; io.a = '0; io.b = '0; io.c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk("rst/in_ready", 32'(io.in_ready), 1);
    chk("rst/out_valid", 32'(io.out_valid), 0);
    chk("rst/d", 32'(io.d), 0);
    chk("rst/err", 32'(io.err), 0);

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vt[i]);

    // Backpressure: result held, inputs ignored while waiting in DONE.
    io.out_ready = 1'b0;
    run_op("bp", vt[0]);
    for (int k = 0; k < 5; k++) begin
      io.in_valid = 1'b1;
      io.sum = 8'($urandom); io.a = 6'($urandom); io.b = 6'($urandom); io.c = 6'($urandom);
      @(negedge clk);
      chk($sformatf("bp%0d/out_valid", k), 32'(io.out_valid), 1);
      chk($sformatf("bp%0d/d", k), 32'(io.d), 40);
      chk($sformatf("bp%0d/err", k), 32'(io.err), 0);
      chk($sformatf("bp%0d/in_ready", k), 32'(io.in_ready), 0);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    chk("bp/out_valid_clr", 32'(io.out_valid), 0);
    chk("bp/in_ready_back", 32'(io.in_ready), 1);

    // Reset asserted for one edge while in SUB2 discards the in-flight result.
    io.in_valid = 1'b1; io.sum = 8'd100; io.a = 6'd10; io.b = 6'd20; io.c = 6'd30;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_rst/out_valid", 32'(io.out_valid), 0);
    chk("mid_rst/d", 32'(io.d), 0);
    chk("mid_rst/err", 32'(io.err), 0);
    chk("mid_rst/in_ready", 32'(io.in_ready), 1);
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (io.out_valid) seen++;
      end
      chk("mid_rst/no_result", 32'(seen), 0);
    end
    run_op("post_rst", vt[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
